// File: rtl/freq_timer_pkg.sv
// Shared constants and types for the frequency timer.
package freq_timer_pkg;

    localparam int unsigned PERIOD_WIDTH_DEFAULT = 13;
    localparam int unsigned TICK_COUNT_WIDTH     = 16;

    typedef logic [PERIOD_WIDTH_DEFAULT-1:0] period_t;

endpackage

// File: rtl/frequency_timer.sv
// Programmable tick generator: one registered high cycle every frequency_timer_period clocks.
// Optional FREQUENCY_TIMER_TICK_COUNT_EN adds a 16-bit wrapping count of emitted ticks.
module frequency_timer
    import freq_timer_pkg::*;
#(
    parameter int unsigned PERIOD_WIDTH = PERIOD_WIDTH_DEFAULT
) (
    input  logic                    system_clock,
    input  logic                    reset,
    input  logic [PERIOD_WIDTH-1:0] frequency_timer_period,
    output logic                    frequency_timer_clock
`ifdef FREQUENCY_TIMER_TICK_COUNT_EN
    ,
    output logic [TICK_COUNT_WIDTH-1:0] tick_count
`endif
);

    logic [PERIOD_WIDTH-1:0] cnt;
    logic [PERIOD_WIDTH-1:0] cnt_next;
    logic                    clk_next;

    // Period zero stalls the timer; the P-1 compare is only reached for P >= 1.
    always_comb begin
        cnt_next = '0;
        clk_next = 1'b0;
        if (frequency_timer_period != '0) begin
            if (cnt >= frequency_timer_period - PERIOD_WIDTH'(1)) begin
                clk_next = 1'b1;
            end else begin
                cnt_next = cnt + PERIOD_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge system_clock or negedge reset) begin
        if (!reset) begin
            cnt                   <= '0;
            frequency_timer_clock <= 1'b0;
        end else begin
            cnt                   <= cnt_next;
            frequency_timer_clock <= clk_next;
        end
    end

`ifdef FREQUENCY_TIMER_TICK_COUNT_EN
    // Counts every edge that registers a tick; wraps naturally at 16 bits.
    always_ff @(posedge system_clock or negedge reset) begin
        if (!reset) begin
            tick_count <= '0;
        end else if (clk_next) begin
            tick_count <= tick_count + TICK_COUNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_frequency_timer.sv
// Self-checking bench for frequency_timer: vector table, corner sequences and randomized periods.
module tb_frequency_timer;

    logic        system_clock = 1'b0;
    logic        reset        = 1'b0;
    logic [12:0] period_in    = '0;
    logic        frequency_timer_clock;
`ifdef FREQUENCY_TIMER_TICK_COUNT_EN
    logic [15:0] tick_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state: cycles elapsed in the current period, expected output, ticks emitted.
    int per     = 0;
    int m_cnt   = 0;
    int m_out   = 0;
    int m_ticks = 0;

    frequency_timer dut (
        .system_clock          (system_clock),
        .reset                 (reset),
        .frequency_timer_period(period_in),
        .frequency_timer_clock (frequency_timer_clock)
`ifdef FREQUENCY_TIMER_TICK_COUNT_EN
        ,
        .tick_count            (tick_count)
`endif
    );

    always #5 system_clock = ~system_clock;

    typedef struct {
        int period;
        int cycles;
        int exp_pulses;
        int exp_first;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_period(input int p);
        per       = p;
        period_in = 13'(p);
    endtask

    // One clock edge: advance the reference, then compare just after the edge.
    task automatic step(input string tag);
        @(posedge system_clock);
        if (per == 0) begin
            m_cnt = 0;
            m_out = 0;
        end else if (m_cnt + 1 >= per) begin
            m_cnt = 0;
            m_out = 1;
            m_ticks++;
        end else begin
            m_cnt++;
            m_out = 0;
        end
        #1;
        check({tag, "_clk"}, int'(frequency_timer_clock), m_out);
        check({tag, "_cnt"}, int'(dut.cnt), m_cnt);
`ifdef FREQUENCY_TIMER_TICK_COUNT_EN
        check({tag, "_ticks"}, int'(tick_count), m_ticks % 65536);
`endif
    endtask

    task automatic apply_reset();
        @(negedge system_clock);
        reset   = 1'b0;
        m_cnt   = 0;
        m_out   = 0;
        m_ticks = 0;
        @(negedge system_clock);
        check("rst_clk", int'(frequency_timer_clock), 0);
        check("rst_cnt", int'(dut.cnt), 0);
        @(negedge system_clock);
        reset = 1'b1;
    endtask

    initial begin
        int pulses;
        int first;
        int last;
        int gap_err;

        vecs[0] = '{period: 4, cycles: 20,  exp_pulses: 5,  exp_first: 4};
        vecs[1] = '{period: 0, cycles: 100, exp_pulses: 0,  exp_first: -1};
        vecs[2] = '{period: 1, cycles: 10,  exp_pulses: 10, exp_first: 1};
        vecs[3] = '{period: 3, cycles: 9,   exp_pulses: 3,  exp_first: 3};
        vecs[4] = '{period: 7, cycles: 20,  exp_pulses: 2,  exp_first: 7};
        vecs[5] = '{period: 2, cycles: 11,  exp_pulses: 5,  exp_first: 2};

        // Table: fixed period from reset release.
        foreach (vecs[i]) begin
            set_period(vecs[i].period);
            apply_reset();
            pulses = 0;
            first  = -1;
            for (int c = 1; c <= vecs[i].cycles; c++) begin
                step("tbl");
                if (frequency_timer_clock) begin
                    pulses++;
                    if (first < 0) first = c;
                end
                if (vecs[i].period == 4)
                    check("duty4", int'(frequency_timer_clock), (c % 4 == 0) ? 1 : 0);
            end
            check("tbl_pulses", pulses, vecs[i].exp_pulses);
            check("tbl_first", first, vecs[i].exp_first);
        end

        // Stalled at zero, then period 3 gives first pulse on the third edge.
        set_period(0);
        apply_reset();
        repeat (100) step("p0");
        @(negedge system_clock);
        set_period(3);
        for (int k = 1; k <= 3; k++) begin
            step("p0to3");
            check("p0to3_edge", int'(frequency_timer_clock), (k == 3) ? 1 : 0);
        end

        // Shrink mid-count: 100 -> 10 at cnt 50 pulses on the next edge.
        set_period(100);
        apply_reset();
        repeat (50) step("shr");
        check("shr_cnt50", int'(dut.cnt), 50);
        @(negedge system_clock);
        set_period(10);
        step("shr");
        check("shr_imm", int'(frequency_timer_clock), 1);
        for (int k = 1; k <= 30; k++) begin
            step("shr");
            check("shr_every10", int'(frequency_timer_clock), (k % 10 == 0) ? 1 : 0);
        end

        // Raise mid-count: 4 -> 10 at cnt 2 pulses on the eighth edge, none before.
        set_period(4);
        apply_reset();
        repeat (2) step("grow");
        @(negedge system_clock);
        set_period(10);
        for (int k = 1; k <= 8; k++) begin
            step("grow");
            check("grow_edge", int'(frequency_timer_clock), (k == 8) ? 1 : 0);
        end

        // Async reset mid-period with no clock edge, then a fresh period of 8.
        set_period(8);
        apply_reset();
        repeat (5) step("arst");
        check("arst_cnt5", int'(dut.cnt), 5);
        #2;
        reset   = 1'b0;
        m_cnt   = 0;
        m_out   = 0;
        m_ticks = 0;
        #1;
        check("arst_clk_now", int'(frequency_timer_clock), 0);
        check("arst_cnt_now", int'(dut.cnt), 0);
        @(negedge system_clock);
        reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step("arst");
            check("arst_edge", int'(frequency_timer_clock), (k % 8 == 0) ? 1 : 0);
        end

        // Randomized period changes against the reference.
        set_period(5);
        apply_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(7, 0) == 0) begin
                @(negedge system_clock);
                set_period(int'($urandom_range(20, 0)));
            end
            step("rnd");
        end

        // Maximum period: pulses exactly 8191 edges apart.
        set_period(8191);
        apply_reset();
        first   = -1;
        last    = -1;
        gap_err = 0;
        pulses  = 0;
        for (int c = 1; c <= 16382; c++) begin
            step("max");
            if (frequency_timer_clock) begin
                pulses++;
                if (first < 0) first = c;
                else if (c - last != 8191) gap_err++;
                last = c;
            end
        end
        check("max_first", first, 8191);
        check("max_last", last, 16382);
        check("max_pulses", pulses, 2);
        check("max_gaps", gap_err, 0);

`ifdef FREQUENCY_TIMER_TICK_COUNT_EN
        // Period 1 for 65536 edges wraps the tick counter back to zero.
        set_period(1);
        apply_reset();
        repeat (65535) step("wrap");
        check("wrap_ffff", int'(tick_count), 65535);
        step("wrap");
        check("wrap_zero", int'(tick_count), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frequency_timer.md
FREQUENCY_TIMER -- requirements
Module: frequency_timer

Interface
REQ-001 SHALL have parameter PERIOD_WIDTH, default 13, giving the bit width of the period input and internal counter.
REQ-002 SHALL have port system_clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset (low = in reset), keeping the codebase port name.
REQ-004 SHALL have port frequency_timer_period, input, PERIOD_WIDTH, the tick period in system_clock cycles (unsigned).
REQ-005 SHALL have port frequency_timer_clock, input-derived output, 1, registered tick pulse used downstream as a clock edge source.

Function
REQ-006 SHALL hold an internal up-counter cnt of PERIOD_WIDTH bits, counting system_clock cycles within the current period.
REQ-007 SHALL, each rising edge with period P != 0: if cnt >= P-1, set cnt to 0 and drive frequency_timer_clock high; else increment cnt and drive frequency_timer_clock low.
REQ-008 SHALL therefore produce exactly one high cycle every P system_clock cycles, with the first high cycle registered at the P-th rising edge after reset deassertion.
REQ-009 SHALL, with P = 0, hold cnt at 0 and frequency_timer_clock low (timer stalled, no edges).
REQ-010 SHALL, with P = 1, drive frequency_timer_clock high on every cycle after the first edge (continuous high; no further rising edges).
REQ-011 SHALL sample frequency_timer_period every cycle with no latching; a new period applies to the current count immediately.
REQ-012 SHALL, when the period is lowered to a value with P-1 <= cnt, emit a pulse and reload to 0 at the next edge (no wrap through the full counter range).
REQ-013 SHALL, when the period is raised mid-count, continue counting from the current cnt to the new P-1 without an extra pulse.
REQ-014 SHALL perform the P-1 comparison without underflow (P = 0 handled by REQ-009 before comparison).
REQ-015 SHALL drive frequency_timer_clock directly from a flop (glitch-free, no combinational path from inputs).

Reset
REQ-016 SHALL, while reset is low, asynchronously force cnt to 0 and frequency_timer_clock to 0.
REQ-017 SHALL, on reset assertion mid-period, abandon the current period; counting restarts from 0 on the first edge after release.

Configuration
REQ-018 SHALL, when macro FREQUENCY_TIMER_TICK_COUNT_EN is defined, add output tick_count (16 bits) incrementing by 1 on every edge where frequency_timer_clock is registered high, wrapping 0xFFFF to 0x0000, reset to 0.
REQ-019 SHALL, when FREQUENCY_TIMER_TICK_COUNT_EN is undefined, omit tick_count and its logic entirely; all other behaviour identical.

Structure
REQ-020 SHALL place constant PERIOD_WIDTH_DEFAULT (13) and typedef period_t (logic [PERIOD_WIDTH_DEFAULT-1:0]) in shared package freq_timer_pkg.
REQ-021 SHALL be a single flat module; no sub-module is needed.

Verification
REQ-022 SHALL verify period 4 from reset release: frequency_timer_clock high exactly on cycles 4, 8, 12, ..., low otherwise, 25% duty.
REQ-023 SHALL verify period 0: output stays low and cnt stays 0 for 100 cycles; then switching to 3 yields first pulse 3 cycles later.
REQ-024 SHALL verify shrink: period 100, at cnt = 50 change to 10 -> pulse on next edge, then every 10 cycles.
REQ-025 SHALL verify async reset asserted mid-period (period 8, cnt = 5): output and cnt go 0 immediately without a clock edge; first pulse 8 cycles after release.
REQ-026 SHALL verify period 8191 (maximum): pulses spaced exactly 8191 cycles apart; with FREQUENCY_TIMER_TICK_COUNT_EN, tick_count equals number of pulses and wraps after 65536 pulses (period 1 run).
